// File: rtl/demux4s_buf.sv
// 1-to-4 demultiplexer. Each output channel has a one-word holding register and its own valid/ready handshake.
// Optional per-channel drain counters (c0..c3) are built when DEMUX4S_CNT_EN is defined.
module demux4s_buf #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   s,
    input  logic [w-1:0] d,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [w-1:0] o0,
    output logic [w-1:0] o1,
    output logic [w-1:0] o2,
    output logic [w-1:0] o3,
    output logic         v0,
    output logic         v1,
    output logic         v2,
    output logic         v3,
    input  logic         r0,
    input  logic         r1,
    input  logic         r2,
    input  logic         r3,
    output logic         busy
`ifdef DEMUX4S_CNT_EN
    ,
    output logic [15:0]  c0,
    output logic [15:0]  c1,
    output logic [15:0]  c2,
    output logic [15:0]  c3
`endif
);

    logic [3:0]   full;
    logic [3:0]   rv;
    logic [3:0]   drain;
    logic [3:0]   acc_vec;
    logic         acc;
    logic [w-1:0] hold [4];

    assign rv    = {r3, r2, r1, r0};
    assign drain = full & rv;

    // Only the selected channel gates the input: a draining full channel can
    // take a new word in the same cycle, giving one word per cycle per channel.
    assign in_ready = ~full[s] | rv[s];
    assign acc      = in_valid & in_ready;
    assign acc_vec  = acc ? (4'b0001 << s) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                hold[k] <= '0;
            end
        end else begin
            full <= (full & ~drain) | acc_vec;
            if (acc) begin
                hold[s] <= d;
            end
        end
    end

    assign o0 = hold[0];
    assign o1 = hold[1];
    assign o2 = hold[2];
    assign o3 = hold[3];

    assign v0 = full[0];
    assign v1 = full[1];
    assign v2 = full[2];
    assign v3 = full[3];

    assign busy = |full;

`ifdef DEMUX4S_CNT_EN
    logic [15:0] cnt [4];

    // Free-running drain counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (drain[k]) begin
                    cnt[k] <= cnt[k] + 16'd1;
                end
            end
        end
    end

    assign c0 = cnt[0];
    assign c1 = cnt[1];
    assign c2 = cnt[2];
    assign c3 = cnt[3];
`endif

endmodule
